// File: rtl/fft_output_stream.sv
// fft_output_stream: ping-pong frame buffer that accepts FFT samples in any
// index order and streams each completed frame out as wide packed beats.
module fft_output_stream #(
    parameter int SIZE      = 16,
    parameter int SAMPLES   = 2048,
    parameter int OUT_WIDTH = 512
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(SAMPLES)-1:0] wr_index,
    input  logic [SIZE-1:0]            wr_data,
    input  logic                       wr_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic                       out_last,
    output logic [1:0]                 frames_pending
);
    localparam int SPB    = OUT_WIDTH / SIZE;
    localparam int BEATS  = SAMPLES / SPB;
    localparam int IDX_W  = $clog2(SAMPLES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {FREE, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t       bank_st [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [BEAT_W-1:0] beat;
    logic [SIZE-1:0]   mem [2][SAMPLES];

    logic wr_en;
    logic wr_done;
    logic rd_fire;
    logic rd_done;

    assign wr_ready = (bank_st[wr_ptr] == FREE) || (bank_st[wr_ptr] == FILLING);
    assign wr_en    = wr_valid && wr_ready;
    assign wr_done  = wr_en && wr_last;
    assign rd_fire  = out_valid && out_ready;
    assign rd_done  = rd_fire && out_last;

    // Sample storage carries no reset; stale entries are harmless by design.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr][wr_index] <= wr_data;
    end

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < SPB; k++)
            out_data[SIZE*k +: SIZE] = mem[rd_ptr][IDX_W'(32'(beat) * 32'(SPB) + k)];
    end

    // The write bank is always FREE/FILLING and the read bank FULL/DRAINING
    // whenever either side acts, so the two updates never touch the same bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0]     <= FREE;
            bank_st[1]     <= FREE;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            beat           <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            frames_pending <= 2'd0;
        end else begin
            if (wr_en) begin
                bank_st[wr_ptr] <= wr_last ? FULL : FILLING;
                if (wr_last)
                    wr_ptr <= ~wr_ptr;
            end

            if (bank_st[rd_ptr] == FULL) begin
                bank_st[rd_ptr] <= DRAINING;
                out_valid       <= 1'b1;
                out_last        <= (BEATS == 1);
            end else if (rd_fire) begin
                if (out_last) begin
                    bank_st[rd_ptr] <= FREE;
                    rd_ptr          <= ~rd_ptr;
                    beat            <= '0;
                    out_valid       <= 1'b0;
                    out_last        <= 1'b0;
                end else begin
                    beat     <= beat + 1'b1;
                    out_last <= (32'(beat) + 32'd2 == 32'(BEATS));
                end
            end

            if (wr_done && !rd_done)
                frames_pending <= frames_pending + 2'd1;
            else if (!wr_done && rd_done)
                frames_pending <= frames_pending - 2'd1;
        end
    end
endmodule

// File: tb/tb_fft_output_stream.sv
// Self-checking bench for fft_output_stream: frame-level reference model with
// a beat scoreboard, table-driven back-pressure steps and hand-written corners.
module tb_fft_output_stream;
    localparam int SIZE      = 16;
    localparam int SAMPLES   = 2048;
    localparam int OUT_WIDTH = 512;
    localparam int SPB       = OUT_WIDTH / SIZE;
    localparam int BEATS     = SAMPLES / SPB;
    localparam int IDX_W     = $clog2(SAMPLES);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 wr_valid = 1'b0;
    logic                 wr_ready;
    logic [IDX_W-1:0]     wr_index;
    logic [SIZE-1:0]      wr_data;
    logic                 wr_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic [1:0]           frames_pending;

    fft_output_stream #(.SIZE(SIZE), .SAMPLES(SAMPLES), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index),
        .wr_data(wr_data), .wr_last(wr_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frames_pending(frames_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_q[$];               // bases of completed frames awaiting drain
    int exp_beat = 0;
    bit stall_pending = 0;
    bit rand_ready = 0;
    bit wr_stuck = 0;
    int valid_cycles = 0;
    logic [OUT_WIDTH-1:0] prev_data;

    typedef struct {
        int mode;           // 0 in-order, 1 bit-reversed, -1 single write while full
        int base;
        bit exp_wr_ready;
        int exp_fp;
        bit exp_valid;
    } step_t;

    function automatic logic [SIZE-1:0] fval(int base, int idx);
        return SIZE'(idx + base * 977);
    endfunction

    function automatic int bitrev(int v);
        int r = 0;
        for (int b = 0; b < IDX_W; b++)
            if (v[b]) r |= (1 << (IDX_W - 1 - b));
        return r;
    endfunction

    task automatic check(string name, logic [OUT_WIDTH-1:0] act, logic [OUT_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(int idx, logic [SIZE-1:0] d, bit is_last, int base);
        int n = 0;
        if (wr_stuck) return;
        while (!wr_ready && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!wr_ready) begin
            checks++;
            failures++;
            wr_stuck = 1;
            $display("FAIL wr_ready_timeout: got 0 expected 1");
            return;
        end
        wr_valid = 1'b1;
        wr_index = IDX_W'(idx);
        wr_data  = d;
        wr_last  = is_last;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (is_last) exp_q.push_back(base);
    endtask

    task automatic write_frame(int mode, int base, bit hold_last);
        int ord[SAMPLES];
        for (int i = 0; i < SAMPLES; i++)
            ord[i] = (mode == 1) ? bitrev(i) : i;
        if (mode == 2) begin
            for (int i = SAMPLES - 1; i > 0; i--) begin
                int j = int'($urandom_range(i, 0));
                int t = ord[i];
                ord[i] = ord[j];
                ord[j] = t;
            end
        end
        for (int i = 0; i < SAMPLES; i++) begin
            bit is_last = (i == SAMPLES - 1);
            if (is_last && hold_last) break;
            if (mode == 2 && $urandom_range(7, 0) == 0)
                do_write(ord[i], SIZE'($urandom), 1'b0, base);
            do_write(ord[i], fval(base, ord[i]), is_last, base);
        end
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_frames_left"}, exp_q.size(), 0);
        check({name, "_fp"}, frames_pending, 0);
    endtask

    initial begin
        step_t steps[3];
        steps[0] = '{0, 11, 1'b1, 1, 1'b1};
        steps[1] = '{1, 0, 1'b0, 2, 1'b1};
        steps[2] = '{-1, 33, 1'b0, 2, 1'b1};
        wr_index = '0;
        wr_data  = '0;

        fork
            begin : monitor
                logic [OUT_WIDTH-1:0] e;
                forever begin
                    @(negedge clk);
                    if (stall_pending) begin
                        check("stall_valid", out_valid, 1);
                        check("stall_data", out_data, prev_data);
                    end
                    stall_pending = 0;
                    if (out_valid && rst_n) begin
                        valid_cycles++;
                        if (exp_q.size() == 0) begin
                            check("unexpected_valid", out_valid, 0);
                        end else begin
                            for (int k = 0; k < SPB; k++)
                                e[k*SIZE +: SIZE] = fval(exp_q[0], exp_beat * SPB + k);
                            check($sformatf("beat%0d_data", exp_beat), out_data, e);
                            check($sformatf("beat%0d_last", exp_beat), out_last, (exp_beat == BEATS - 1));
                            if (out_ready) begin
                                exp_beat++;
                                if (exp_beat == BEATS) begin
                                    exp_beat = 0;
                                    void'(exp_q.pop_front());
                                end
                            end else begin
                                stall_pending = 1;
                                prev_data = out_data;
                            end
                        end
                    end
                end
            end
            begin : ready_toggler
                forever begin
                    @(posedge clk); #1;
                    if (rand_ready) out_ready = ($urandom_range(1, 0) == 1);
                end
            end
            begin : watchdog
                #3000000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_frames_pending", frames_pending, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // In-order frame, value = index: one-cycle latency, full-rate drain
        out_ready = 1'b1;
        valid_cycles = 0;
        write_frame(0, 0, 1'b1);
        do_write(SAMPLES - 1, fval(0, SAMPLES - 1), 1'b1, 0);
        check("valid_before_latency", out_valid, 0);
        check("fp_after_last", frames_pending, 1);
        check("wr_ready_other_bank", wr_ready, 1);
        @(posedge clk); #1;
        check("valid_after_latency", out_valid, 1);
        wait_drain("drain_inorder");
        check("drain_cycles", valid_cycles, BEATS);

        // Back-pressure table: fill both banks, then a write that must be ignored
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (steps[s].mode < 0) begin
                wr_valid = 1'b1;
                wr_index = IDX_W'(5);
                wr_data  = 16'hDEAD;
                wr_last  = 1'b1;
                @(posedge clk); #1;
                wr_valid = 1'b0;
                wr_last  = 1'b0;
            end else begin
                write_frame(steps[s].mode, steps[s].base, 1'b0);
            end
            @(posedge clk); #1;
            check($sformatf("step%0d_wr_ready", s), wr_ready, steps[s].exp_wr_ready);
            check($sformatf("step%0d_fp", s), frames_pending, steps[s].exp_fp);
            check($sformatf("step%0d_valid", s), out_valid, steps[s].exp_valid);
        end
        out_ready = 1'b1;
        wait_drain("drain_table");

        // Final beat of frame A and wr_last of frame B on the same edge
        out_ready = 1'b0;
        write_frame(0, 44, 1'b0);
        write_frame(0, 55, 1'b1);
        check("fp_before_coincide", frames_pending, 1);
        out_ready = 1'b1;
        repeat (BEATS - 1) @(posedge clk);
        #1;
        do_write(SAMPLES - 1, fval(55, SAMPLES - 1), 1'b1, 55);
        check("fp_coincide", frames_pending, 1);
        check("valid_gap", out_valid, 0);
        @(posedge clk); #1;
        check("frame2_valid", out_valid, 1);
        wait_drain("drain_coincide");

        // Random order with overwrites, random out_ready
        rand_ready = 1;
        write_frame(2, 66, 1'b0);
        write_frame(2, 77, 1'b0);
        wait_drain("drain_random");
        rand_ready = 0;
        out_ready = 1'b1;

        // Reset asserted while beat 10 is presented
        out_ready = 1'b0;
        write_frame(0, 88, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_beat = 0;
        stall_pending = 0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_fp", frames_pending, 0);
        check("midrst_wr_ready", wr_ready, 1);
        check("midrst_out_last", out_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        write_frame(0, 99, 1'b0);
        wait_drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_output_stream.md
FFT_OUTPUT_STREAM -- requirements
Module: fft_output_stream

Interface
REQ-001 Parameter SIZE, default 16, bits per FFT result sample.
REQ-002 Parameter SAMPLES, default 2048, samples per frame; power of two.
REQ-003 Parameter OUT_WIDTH, default 512, output beat width; multiple of SIZE.
REQ-004 Derived constants: SPB = OUT_WIDTH/SIZE samples per beat; BEATS = SAMPLES/SPB beats per frame; SAMPLES shall be a multiple of SPB.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 wr_valid  input  1  write request.
REQ-008 wr_ready  output  1  a bank is available for writing.
REQ-009 wr_index  input  clog2(SAMPLES)  sample position, any order (e.g. bit-reversed).
REQ-010 wr_data  input  SIZE  sample value.
REQ-011 wr_last  input  1  final write of the current frame.
REQ-012 out_valid  output  1  out_data holds a valid beat.
REQ-013 out_ready  input  1  downstream accepts the beat.
REQ-014 out_data  output  OUT_WIDTH  packed beat.
REQ-015 out_last  output  1  current beat is beat BEATS-1.
REQ-016 frames_pending  output  2  number of FULL or DRAINING banks (0..2).

Function
REQ-017 Storage: two banks (ping-pong) of SAMPLES x SIZE; each bank has state FREE, FILLING, FULL or DRAINING.
REQ-018 A write is accepted when wr_valid && wr_ready; it stores wr_data at wr_index in the write bank and moves that bank from FREE to FILLING.
REQ-019 wr_ready is high iff the write bank is FREE or FILLING.
REQ-020 An accepted write with wr_last moves the write bank to FULL on the same edge and toggles the write-bank pointer.
REQ-021 Writes to the same index within one frame overwrite; unwritten indices hold stale data; no error is flagged.
REQ-022 When the read bank is FULL, it moves to DRAINING and out_valid rises on the following cycle.
REQ-023 While DRAINING, out_data[SIZE*k +: SIZE] equals sample beat*SPB + k for k = 0..SPB-1; out_data is combinational from bank and beat counter.
REQ-024 A beat transfers when out_valid && out_ready; beat increments; out_data and out_valid hold stable while out_ready is low.
REQ-025 A transfer with out_last returns the bank to FREE, resets beat to 0, and toggles the read-bank pointer; out_valid drops for at least one cycle before the next frame.
REQ-026 Simultaneous wr_last into one bank and final beat out of the other: both take effect on the same edge.
REQ-027 With both banks FULL/DRAINING, wr_ready is low; wr_valid is ignored, with no write and no state change.
REQ-028 frames_pending updates on the same edge as the state change it reflects; increment and decrement on the same edge leave it unchanged.
REQ-029 Throughput: with out_ready held high, one beat per cycle; frame drain takes BEATS cycles.

Reset
REQ-030 On rst_n low: both banks FREE, both pointers to bank 0, beat = 0, out_valid = 0, out_last = 0, wr_ready = 1, frames_pending = 0.
REQ-031 Storage contents are not reset; out_data is don't-care while out_valid = 0.
REQ-032 Reset mid-frame or mid-drain discards all frames; the first write after release goes to bank 0.

Verification
REQ-033 Defaults: write 2048 samples with value = index, last at index 2047 -> out_valid rises 1 cycle later; beat 0 lanes hold 0..31; 64 beats; out_last only on beat 63.
REQ-034 Write in bit-reversed order -> output beats identical to in-order case.
REQ-035 Write 3 frames back-to-back with out_ready = 0 -> wr_ready drops after frame 2's last write; frames_pending = 2; the third-frame write is ignored.
REQ-036 Random out_ready toggling -> out_data stable while stalled; no beat lost or duplicated across 2 frames.
REQ-037 Frame-2 wr_last on the same edge as frame-1's final beat -> frames_pending stays 1; frame 2 drains next.
REQ-038 Assert rst_n low during beat 10 of a drain -> out_valid = 0, frames_pending = 0 immediately; a new frame drains correctly from bank 0.
